// File: rtl/mem_stage_lsu.sv
// Purpose: MEM-stage load/store unit; one outstanding data-bus access, formats load data for MEM/WB.
// Latency: access seen in IDLE, bus_req from the next cycle, result in DONE; 2 stall cycles minimum.
// Backpressure: stall_mem holds the pipeline until bus_ready or timeout; faulting accesses never stall.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] write_data_mem,
    input  logic [2:0]  funct3_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    output logic [31:0] read_data_mem,
    output logic        stall_mem,
    output logic        misalign_fault,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    // Wide enough to hold TIMEOUT_CYCLES-1 even for tiny parameter values.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [2:0]      funct3_q;
    logic            we_q;
    logic [CW-1:0]   cnt_q;

    logic            is_req;
    logic            is_load;
    logic            is_store;
    logic            f3_ok;
    logic            align_ok;
    logic            acc_valid;
    logic            timeout_hit;
    logic            accept;

    // Legality of the access currently presented by EX/MEM (direction, size, alignment).
    always_comb begin
        is_req   = mem_read_mem | mem_write_mem;
        is_load  = mem_read_mem & ~mem_write_mem;
        is_store = mem_write_mem & ~mem_read_mem;
        f3_ok    = 1'b0;
        align_ok = 1'b0;
        case (funct3_mem)
            3'b000: begin
                f3_ok    = is_load | is_store;
                align_ok = 1'b1;
            end
            3'b001: begin
                f3_ok    = is_load | is_store;
                align_ok = ~alu_result_mem[0];
            end
            3'b010: begin
                f3_ok    = is_load | is_store;
                align_ok = (alu_result_mem[1:0] == 2'b00);
            end
            3'b100: begin
                f3_ok    = is_load;
                align_ok = 1'b1;
            end
            3'b101: begin
                f3_ok    = is_load;
                align_ok = ~alu_result_mem[0];
            end
            default: begin
                f3_ok    = 1'b0;
                align_ok = 1'b0;
            end
        endcase
        acc_valid   = f3_ok & align_ok;
        timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state logic plus the control outputs (stall, fault pulses, request).
    always_comb begin
        state_d        = state_q;
        stall_mem      = 1'b0;
        misalign_fault = 1'b0;
        bus_error      = 1'b0;
        bus_req        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // No new access is accepted while reset is held.
                if (!reset && is_req) begin
                    if (acc_valid) begin
                        stall_mem = 1'b1;
                        state_d   = S_WAIT;
                    end else begin
                        misalign_fault = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                bus_req   = 1'b1;
                stall_mem = 1'b1;
                if (bus_ready) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    bus_error = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        accept = (state_q == S_IDLE) && (state_d == S_WAIT);
    end

    // Bus address/enables/data come only from latched values, so EX/MEM may change while stalled.
    always_comb begin
        bus_we    = 1'b0;
        bus_addr  = 32'd0;
        bus_be    = 4'd0;
        bus_wdata = 32'd0;
        if (state_q == S_WAIT) begin
            bus_we   = we_q;
            bus_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
                case (funct3_q[1:0])
                    2'b00: begin
                        bus_be    = 4'b0001 << addr_q[1:0];
                        bus_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        bus_be    = 4'b0011 << addr_q[1:0];
                        bus_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        bus_be    = 4'b1111;
                        bus_wdata = wdata_q;
                    end
                endcase
            end else begin
                bus_be = 4'b1111;
            end
        end
    end

    // Lane select and sign/zero extension of the captured word; zero outside DONE.
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        case (addr_q[1:0])
            2'b00:   ld_byte = rdata_q[7:0];
            2'b01:   ld_byte = rdata_q[15:8];
            2'b10:   ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half       = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        read_data_mem = 32'd0;
        if (state_q == S_DONE) begin
            case (funct3_q)
                3'b000:  read_data_mem = {{24{ld_byte[7]}}, ld_byte};
                3'b001:  read_data_mem = {{16{ld_half[15]}}, ld_half};
                3'b010:  read_data_mem = rdata_q;
                3'b100:  read_data_mem = {24'd0, ld_byte};
                3'b101:  read_data_mem = {16'd0, ld_half};
                default: read_data_mem = 32'd0;
            endcase
        end
    end

    // State register, access latches, timeout counter and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= alu_result_mem;
                wdata_q  <= write_data_mem;
                funct3_q <= funct3_mem;
                we_q     <= mem_write_mem;
                cnt_q    <= '0;
            end else if (state_q == S_WAIT) begin
                if (bus_ready) begin
                    // Stores capture zero so DONE presents 0 to MEM/WB.
                    rdata_q <= we_q ? 32'd0 : bus_rdata;
                end else if (timeout_hit) begin
                    rdata_q <= 32'd0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Purpose: directed checks of mem_stage_lsu loads, stores, faults, timeout and reset abort.
// Latency: one directed step per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: bus_ready is driven by the bench to model slow, fast and absent completions.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result_mem;
    logic [31:0] write_data_mem;
    logic [2:0]  funct3_mem;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [31:0] read_data_mem;
    logic        stall_mem;
    logic        misalign_fault;
    logic        bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_result_mem (alu_result_mem),
        .write_data_mem (write_data_mem),
        .funct3_mem     (funct3_mem),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .read_data_mem  (read_data_mem),
        .stall_mem      (stall_mem),
        .misalign_fault (misalign_fault),
        .bus_error      (bus_error),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_ready      (bus_ready),
        .bus_rdata      (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid access: ready arrives on WAIT cycle number wait_cycles.
    task automatic access(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input bit rd, input logic [31:0] wd, input int wait_cycles,
                          input logic [31:0] rdata, input logic [31:0] exp_rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
        int stalls;
        alu_result_mem = a;
        funct3_mem     = f3;
        mem_read_mem   = rd;
        mem_write_mem  = !rd;
        write_data_mem = wd;
        #1;
        stalls = stall_mem ? 1 : 0;
        chk({tag, "_idle_req"}, {31'd0, bus_req}, 32'd0);
        for (int k = 0; k < wait_cycles; k++) begin
            tick();
            // EX/MEM may change while stalled; the DUT must use latched values.
            alu_result_mem = ~a;
            write_data_mem = ~wd;
            bus_ready = (k == wait_cycles - 1);
            bus_rdata = (k == wait_cycles - 1) ? rdata : 32'h1357_9BDF;
            #1;
            if (stall_mem) stalls++;
            if (!bus_req) chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
            if (bus_error) chk({tag, "_noerr"}, {31'd0, bus_error}, 32'd0);
        end
        chk({tag, "_addr"}, bus_addr, exp_addr);
        chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        chk({tag, "_wdata"}, bus_wdata, exp_wdata);
        chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, !rd});
        tick();
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        #1;
        chk({tag, "_done_stall"}, {31'd0, stall_mem}, 32'd0);
        chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_rdata"}, read_data_mem, exp_rd);
        chk({tag, "_stalls"}, stalls, wait_cycles + 1);
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        tick();
        chk({tag, "_idle_rd"}, read_data_mem, 32'd0);
    endtask

    // An illegal access: one-cycle fault, no stall, no bus activity.
    task automatic fault(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input bit rd, input bit wr);
        alu_result_mem = a;
        funct3_mem     = f3;
        mem_read_mem   = rd;
        mem_write_mem  = wr;
        write_data_mem = 32'h1234_5678;
        #1;
        chk({tag, "_fault"}, {31'd0, misalign_fault}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stall_mem}, 32'd0);
        chk({tag, "_rd"}, read_data_mem, 32'd0);
        tick();
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        #1;
        chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_pulse"}, {31'd0, misalign_fault}, 32'd0);
    endtask

    initial begin
        int reqs;
        int errs;
        int err_at;
        reset          = 1'b1;
        alu_result_mem = 32'd0;
        write_data_mem = 32'd0;
        funct3_mem     = 3'd0;
        mem_read_mem   = 1'b0;
        mem_write_mem  = 1'b0;
        bus_ready      = 1'b0;
        bus_rdata      = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_rd", read_data_mem, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_err", {30'd0, bus_error, misalign_fault}, 32'd0);
        reset = 1'b0;
        tick();

        access("lw",  32'h100, 3'b010, 1'b1, 32'h0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 4'hF, 32'h0);
        access("lb",  32'h103, 3'b000, 1'b1, 32'h0, 1, 32'h80FF_1234, 32'hFFFF_FF80, 32'h100, 4'hF, 32'h0);
        access("lbu", 32'h103, 3'b100, 1'b1, 32'h0, 1, 32'h80FF_1234, 32'h0000_0080, 32'h100, 4'hF, 32'h0);
        access("lhu", 32'h102, 3'b101, 1'b1, 32'h0, 1, 32'h80FF_1234, 32'h0000_80FF, 32'h100, 4'hF, 32'h0);
        access("lh",  32'h102, 3'b001, 1'b1, 32'h0, 2, 32'h80FF_1234, 32'hFFFF_80FF, 32'h100, 4'hF, 32'h0);
        access("sb",  32'h201, 3'b000, 1'b0, 32'h0000_00A5, 3, 32'hFFFF_FFFF, 32'h0, 32'h200, 4'b0010, 32'hA5A5_A5A5);
        access("sh",  32'h20E, 3'b001, 1'b0, 32'h1234_BEEF, 2, 32'hFFFF_FFFF, 32'h0, 32'h20C, 4'b1100, 32'hBEEF_BEEF);
        access("sw",  32'h300, 3'b010, 1'b0, 32'h1234_5678, 1, 32'hFFFF_FFFF, 32'h0, 32'h300, 4'hF, 32'h1234_5678);

        fault("lw_mis",  32'h102, 3'b010, 1'b1, 1'b0);
        fault("sh_mis",  32'h001, 3'b001, 1'b0, 1'b1);
        fault("both",    32'h100, 3'b010, 1'b1, 1'b1);
        fault("sbu_ill", 32'h100, 3'b100, 1'b0, 1'b1);
        fault("ld_f3",   32'h100, 3'b011, 1'b1, 1'b0);

        // Timeout: bus_ready never arrives.
        alu_result_mem = 32'h400;
        funct3_mem     = 3'b010;
        mem_read_mem   = 1'b1;
        bus_rdata      = 32'hCAFE_F00D;
        #1;
        tick();
        reqs   = 0;
        errs   = 0;
        err_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_error) begin
                errs++;
                err_at = reqs + 1;
            end
            if (!bus_req) break;
            reqs++;
            tick();
        end
        chk("to_reqs", reqs, 32'd16);
        chk("to_errs", errs, 32'd1);
        chk("to_err_at", err_at, 32'd16);
        chk("to_done_rd", read_data_mem, 32'd0);
        chk("to_done_stall", {31'd0, stall_mem}, 32'd0);
        mem_read_mem = 1'b0;
        tick();
        chk("to_idle_req", {31'd0, bus_req}, 32'd0);

        // Reset during the second WAIT cycle, then a late bus_ready.
        alu_result_mem = 32'h500;
        funct3_mem     = 3'b010;
        mem_read_mem   = 1'b1;
        #1;
        tick();
        chk("rw_wait1_req", {31'd0, bus_req}, 32'd1);
        tick();
        reset        = 1'b1;
        mem_read_mem = 1'b0;
        tick();
        reset     = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 32'h7777_7777;
        #1;
        chk("rw_req", {31'd0, bus_req}, 32'd0);
        chk("rw_stall", {31'd0, stall_mem}, 32'd0);
        chk("rw_rd", read_data_mem, 32'd0);
        tick();
        bus_ready = 1'b0;
        chk("rw_nodone_rd", read_data_mem, 32'd0);
        chk("rw_nodone_req", {31'd0, bus_req}, 32'd0);

        // Recovery: a normal load after the abort.
        access("lw2", 32'h104, 3'b010, 1'b1, 32'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 32'h104, 4'hF, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
